// File: rtl/sync_fifo_flex_if.sv
// Bundle of the FIFO's request/data/status signals shared by producer, consumer and FIFO.
// The master modport belongs to the side that issues requests. The slave modport belongs to the FIFO.
interface sync_fifo_flex_if #(
    parameter int DEPTH      = 64,
    parameter int DATA_WIDTH = 32
);
    localparam int PTR_WIDTH = $clog2(DEPTH);

    logic                  flush;
    logic                  w_en;
    logic [DATA_WIDTH-1:0] data_in;
    logic                  r_en;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  full;
    logic                  empty;
    logic                  almost_full;
    logic                  almost_empty;
    logic [PTR_WIDTH:0]    count;
    logic                  overflow;
    logic                  underflow;

    modport master (
        output flush, w_en, data_in, r_en,
        input  data_out, full, empty, almost_full, almost_empty, count, overflow, underflow
    );

    modport slave (
        input  flush, w_en, data_in, r_en,
        output data_out, full, empty, almost_full, almost_empty, count, overflow, underflow
    );
endinterface

// File: rtl/sync_fifo_flex.sv
// Single-clock FIFO with fill count, almost flags, sticky overflow/underflow and an optional
// first-word-fall-through read port. It uses binary pointers with an extra wrap bit.
module sync_fifo_flex #(
    parameter int DEPTH         = 64,
    parameter int DATA_WIDTH    = 32,
    parameter int AFULL_THRESH  = DEPTH - 4,
    parameter int AEMPTY_THRESH = 4,
    parameter int FWFT          = 0
) (
    input  logic            clk,
    input  logic            rst_n,
    sync_fifo_flex_if.slave bus
);
    localparam int PTR_WIDTH = $clog2(DEPTH);
    localparam int CW        = PTR_WIDTH + 1;

    logic [CW-1:0]         wptr_q, wptr_d, rptr_q, rptr_d, count;
    logic [PTR_WIDTH-1:0]  waddr, raddr;
    logic                  overflow_q, overflow_d, underflow_q, underflow_d;
    logic                  full, empty, wr_ok, rd_ok;
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    assign waddr = wptr_q[PTR_WIDTH-1:0];
    assign raddr = rptr_q[PTR_WIDTH-1:0];
    assign full  = (wptr_q[PTR_WIDTH] != rptr_q[PTR_WIDTH]) && (waddr == raddr);
    assign empty = (wptr_q == rptr_q);
    assign count = wptr_q - rptr_q;

    // Handshake: a write is taken when w_en && !full, and a read is taken when r_en && !empty.
    // Both use the flags at the start of the cycle. A refused request sets its sticky flag. flush overrides both.
    assign wr_ok = bus.w_en & ~full & ~bus.flush;
    assign rd_ok = bus.r_en & ~empty & ~bus.flush;

    always_comb begin
        wptr_d      = wptr_q;
        rptr_d      = rptr_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        if (bus.flush) begin
            wptr_d      = '0;
            rptr_d      = '0;
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end else begin
            if (wr_ok)              wptr_d      = wptr_q + CW'(1);
            if (rd_ok)              rptr_d      = rptr_q + CW'(1);
            if (bus.w_en && full)   overflow_d  = 1'b1;
            if (bus.r_en && empty)  underflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q      <= '0;
            rptr_q      <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (wr_ok) mem_q[waddr] <= bus.data_in;
    end

    generate
        if (FWFT != 0) begin : g_fwft
            assign bus.data_out = empty ? '0 : mem_q[raddr];
        end else begin : g_reg
            logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

            always_comb begin
                rdata_d = rdata_q;
                if (rd_ok) rdata_d = mem_q[raddr];
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) rdata_q <= '0;
                else        rdata_q <= rdata_d;
            end

            assign bus.data_out = rdata_q;
        end
    endgenerate

    assign bus.full         = full;
    assign bus.empty        = empty;
    assign bus.count        = count;
    assign bus.almost_full  = (count >= CW'(AFULL_THRESH));
    assign bus.almost_empty = (count <= CW'(AEMPTY_THRESH));
    assign bus.overflow     = overflow_q;
    assign bus.underflow    = underflow_q;
endmodule

// File: tb/tb_sync_fifo_flex.sv
// Bench for sync_fifo_flex. One instance uses registered read and one uses FWFT. Both see the same stimulus.
// A queue-based model supplies the expected outputs, which are compared on every falling edge.
module tb_sync_fifo_flex;
    localparam int DEPTH = 64;
    localparam int DW    = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          flush, w_en, r_en;
    logic [DW-1:0] data_in;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    sync_fifo_flex_if #(.DEPTH(DEPTH), .DATA_WIDTH(DW)) bus0 ();
    sync_fifo_flex_if #(.DEPTH(DEPTH), .DATA_WIDTH(DW)) bus1 ();

    assign bus0.flush = flush;   assign bus1.flush = flush;
    assign bus0.w_en = w_en;     assign bus1.w_en = w_en;
    assign bus0.r_en = r_en;     assign bus1.r_en = r_en;
    assign bus0.data_in = data_in; assign bus1.data_in = data_in;

    sync_fifo_flex #(.DEPTH(DEPTH), .DATA_WIDTH(DW), .FWFT(0)) u_dut_reg (
        .clk(clk), .rst_n(rst_n), .bus(bus0.slave));
    sync_fifo_flex #(.DEPTH(DEPTH), .DATA_WIDTH(DW), .FWFT(1)) u_dut_fwft (
        .clk(clk), .rst_n(rst_n), .bus(bus1.slave));

    // Reference model: a plain queue plus sticky bits and the last value popped.
    logic [DW-1:0] mq[$];
    logic          m_ovf, m_unf;
    logic [DW-1:0] m_rd0;
    int            m_n;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq.delete(); m_ovf = 1'b0; m_unf = 1'b0; m_rd0 = '0;
        end else if (flush) begin
            mq.delete(); m_ovf = 1'b0; m_unf = 1'b0;
        end else begin
            m_n = mq.size();
            if (r_en) begin
                if (m_n == 0) m_unf = 1'b1;
                else          m_rd0 = mq.pop_front();
            end
            if (w_en) begin
                if (m_n == DEPTH) m_ovf = 1'b1;
                else              mq.push_back(data_in);
            end
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        int n;
        logic [DW-1:0] head;
        n    = mq.size();
        head = (n != 0) ? mq[0] : '0;
        chk("count0",  64'(bus0.count), 64'(n));
        chk("count1",  64'(bus1.count), 64'(n));
        chk("full0",   64'(bus0.full), 64'(n == DEPTH));
        chk("full1",   64'(bus1.full), 64'(n == DEPTH));
        chk("empty0",  64'(bus0.empty), 64'(n == 0));
        chk("empty1",  64'(bus1.empty), 64'(n == 0));
        chk("afull0",  64'(bus0.almost_full), 64'(n >= DEPTH - 4));
        chk("afull1",  64'(bus1.almost_full), 64'(n >= DEPTH - 4));
        chk("aempty0", 64'(bus0.almost_empty), 64'(n <= 4));
        chk("aempty1", 64'(bus1.almost_empty), 64'(n <= 4));
        chk("ovf0",    64'(bus0.overflow), 64'(m_ovf));
        chk("ovf1",    64'(bus1.overflow), 64'(m_ovf));
        chk("unf0",    64'(bus0.underflow), 64'(m_unf));
        chk("unf1",    64'(bus1.underflow), 64'(m_unf));
        chk("dout_reg",  64'(bus0.data_out), 64'(m_rd0));
        chk("dout_fwft", 64'(bus1.data_out), 64'(head));
    endtask

    always @(negedge clk) begin
        if (chk_en && rst_n) compare_all();
    end

    task automatic reset_values(input string tag);
        chk({tag, "_count"},  64'(bus0.count), 64'd0);
        chk({tag, "_empty"},  64'(bus0.empty), 64'd1);
        chk({tag, "_aempty"}, 64'(bus0.almost_empty), 64'd1);
        chk({tag, "_full"},   64'(bus0.full), 64'd0);
        chk({tag, "_afull"},  64'(bus0.almost_full), 64'd0);
        chk({tag, "_ovf"},    64'(bus0.overflow), 64'd0);
        chk({tag, "_unf"},    64'(bus0.underflow), 64'd0);
        chk({tag, "_dout0"},  64'(bus0.data_out), 64'd0);
        chk({tag, "_count1"}, 64'(bus1.count), 64'd0);
        chk({tag, "_dout1"},  64'(bus1.data_out), 64'd0);
    endtask

    // Inputs are presented for one posedge, then return to idle 1 time unit later.
    task automatic drive(input logic w, input logic r, input logic f, input logic [DW-1:0] d);
        w_en = w; r_en = r; flush = f; data_in = d;
        @(posedge clk);
        #1;
        w_en = 1'b0; r_en = 1'b0; flush = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW-1:0] first_v, last_v;
        rst_n = 1'b0; flush = 1'b0; w_en = 1'b0; r_en = 1'b0; data_in = '0;
        repeat (2) @(posedge clk);
        #1;
        reset_values("rst");
        rst_n  = 1'b1;
        chk_en = 1'b1;

        // Registered read: each word appears one cycle after its r_en.
        drive(1, 0, 0, 32'h11);
        drive(1, 0, 0, 32'h22);
        drive(1, 0, 0, 32'h33);
        drive(0, 1, 0, 0); chk("t1_rd_11", 64'(bus0.data_out), 64'h11);
        drive(0, 1, 0, 0); chk("t1_rd_22", 64'(bus0.data_out), 64'h22);
        drive(0, 1, 0, 0); chk("t1_rd_33", 64'(bus0.data_out), 64'h33);
        chk("t1_empty", 64'(bus0.empty), 64'd1);
        chk("t1_count", 64'(bus0.count), 64'd0);

        // Fill to full with the pointers offset by 3, so that draining crosses the wrap.
        for (int i = 0; i < DEPTH; i++) begin
            drive(1, 0, 0, 32'h100 + i);
            if (i + 1 == 59) chk("t2_afull_59", 64'(bus0.almost_full), 64'd0);
            if (i + 1 == 60) chk("t2_afull_60", 64'(bus0.almost_full), 64'd1);
        end
        chk("t2_full", 64'(bus0.full), 64'd1);
        chk("t2_count64", 64'(bus0.count), 64'd64);
        drive(1, 0, 0, 32'hDEAD);
        chk("t2_ovf", 64'(bus0.overflow), 64'd1);
        chk("t2_count_hold", 64'(bus0.count), 64'd64);
        for (int i = 0; i < DEPTH; i++) begin
            drive(0, 1, 0, 0);
            chk("t2_order", 64'(bus0.data_out), 64'(32'h100 + i));
        end
        chk("t2_drained", 64'(bus0.empty), 64'd1);

        // A write and a read together on a full FIFO: the read is taken and the write is dropped.
        drive(0, 0, 1, 0);
        for (int i = 0; i < DEPTH; i++) drive(1, 0, 0, $urandom);
        drive(1, 1, 0, 32'hCAFE);
        chk("t3_count63", 64'(bus0.count), 64'd63);
        chk("t3_ovf", 64'(bus0.overflow), 64'd1);
        drive(0, 0, 1, 0);
        first_v = 32'h5000;
        for (int i = 0; i < 32; i++) drive(1, 0, 0, first_v + i);
        drive(1, 1, 0, 32'hBEEF);
        chk("t3_count32", 64'(bus0.count), 64'd32);
        chk("t3_first", 64'(bus0.data_out), 64'(first_v));
        for (int i = 0; i < 32; i++) drive(0, 1, 0, 0);
        last_v = 32'hBEEF;
        chk("t3_last", 64'(bus0.data_out), 64'(last_v));

        // A read on an empty FIFO sets underflow. A write with a read on empty still stores the word.
        drive(0, 1, 0, 0);
        chk("t4_unf", 64'(bus0.underflow), 64'd1);
        chk("t4_dout_hold", 64'(bus0.data_out), 64'(last_v));
        drive(1, 1, 0, 32'h77);
        chk("t4_count1", 64'(bus0.count), 64'd1);
        chk("t4_unf_sticky", 64'(bus0.underflow), 64'd1);

        // FWFT: the head word is visible without a read request.
        drive(0, 0, 1, 0);
        chk("t5_fwft_empty0", 64'(bus1.data_out), 64'd0);
        drive(1, 0, 0, 32'hA5);
        chk("t5_fwft_a5", 64'(bus1.data_out), 64'hA5);
        drive(0, 1, 0, 0);
        chk("t5_empty", 64'(bus1.empty), 64'd1);
        chk("t5_fwft_zero", 64'(bus1.data_out), 64'd0);

        // Flush clears both the contents and the sticky flags.
        drive(0, 0, 1, 0);
        for (int i = 0; i <= DEPTH; i++) drive(1, 0, 0, $urandom);
        for (int i = 0; i < DEPTH - 10; i++) drive(0, 1, 0, 0);
        chk("t6_count10", 64'(bus0.count), 64'd10);
        chk("t6_ovf_set", 64'(bus0.overflow), 64'd1);
        drive(0, 0, 1, 0);
        chk("t6_flush_count", 64'(bus0.count), 64'd0);
        chk("t6_flush_empty", 64'(bus0.empty), 64'd1);
        chk("t6_flush_ovf", 64'(bus0.overflow), 64'd0);

        // Random traffic. Write and read bias alternate so that the FIFO reaches both full and empty.
        for (int p = 0; p < 8; p++) begin
            int wp, rp;
            wp = (p % 2 == 0) ? 85 : 20;
            rp = (p % 2 == 0) ? 25 : 80;
            for (int c = 0; c < 200; c++) begin
                drive(($urandom_range(99) < wp), ($urandom_range(99) < rp),
                      ($urandom_range(199) == 0), $urandom);
            end
            if (p == 4) begin
                // Asynchronous reset in the middle of the stream.
                for (int i = 0; i < 20; i++) drive(1, 0, 0, $urandom);
                #2 rst_n = 1'b0;
                #1 reset_values("async");
                @(negedge clk);
                #1 rst_n = 1'b1;
            end
        end

        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
